// File: rtl/cache_pkg.sv
// Shared cache geometry, refill FSM encoding and address-field helpers.
package cache_pkg;

  localparam int unsigned INDEX_W  = 3;
  localparam int unsigned WAYS     = 2;
  localparam int unsigned WORDS    = 4;
  localparam int unsigned OFFSET_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WB     = 2'd1,
    ST_FILL   = 2'd2,
    ST_COMMIT = 2'd3
  } refill_state_t;

  // Bit position of the set index inside a byte address.
  function automatic int unsigned index_lsb(input int unsigned words);
    return OFFSET_W + $clog2(words);
  endfunction

  // Bit position of the tag inside a byte address.
  function automatic int unsigned tag_lsb(input int unsigned words);
    return index_lsb(words) + INDEX_W;
  endfunction

endpackage

// File: rtl/refill_beat_counter.sv
// Word counter for refill beats: cleared while idle, advances on each accepted beat.
module refill_beat_counter #(
  parameter int unsigned WORDS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_clr,
  input  logic                     i_en,
  output logic [$clog2(WORDS)-1:0] o_count,
  output logic                     o_last
);

  localparam int unsigned CNT_W = $clog2(WORDS);

  logic [CNT_W-1:0] r_count;

  // Count accepted beats; wraps naturally after the last word of a line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_last  = (r_count == CNT_W'(WORDS - 1));

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss-handling engine: optional dirty-victim write-back, line fill, tag commit.
module cache_refill_ctrl #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned WORDS  = cache_pkg::WORDS,
  parameter int unsigned TAG_W  = ADDR_W - cache_pkg::INDEX_W - $clog2(WORDS) - cache_pkg::OFFSET_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        miss_req,
  input  logic [ADDR_W-1:0]           miss_addr,
  input  logic                        victim_way,
  input  logic                        victim_valid,
  input  logic                        victim_dirty,
  input  logic [TAG_W-1:0]            victim_tag,
  input  logic [DATA_W-1:0]           arr_rdata,
  output logic                        arr_way,
  output logic [cache_pkg::INDEX_W-1:0] arr_index,
  output logic [$clog2(WORDS)-1:0]    arr_word,
  output logic                        arr_we,
  output logic [DATA_W-1:0]           arr_wdata,
  output logic                        tag_we,
  output logic [TAG_W-1:0]            tag_wdata,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic                        mem_ack,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        busy,
  output logic                        done,
  output logic                        policy_update
);

  import cache_pkg::*;

  localparam int unsigned CNT_W   = $clog2(WORDS);
  localparam int unsigned IDX_LSB = index_lsb(WORDS);
  localparam int unsigned TAG_LSB = tag_lsb(WORDS);

  refill_state_t        r_state, w_next;
  logic [TAG_W-1:0]     r_tag, r_vtag;
  logic [INDEX_W-1:0]   r_index;
  logic                 r_way;
  logic [CNT_W-1:0]     w_count;
  logic                 w_last, w_beat, w_accept;
  logic                 w_unused_addr_lo;

  // The refill always starts at word 0, so the word/byte offset of the miss is not needed.
  assign w_unused_addr_lo = ^miss_addr[IDX_LSB-1:0];

  assign w_accept = (r_state == ST_IDLE) && miss_req;
  assign w_beat   = mem_req && mem_ack;

  refill_beat_counter #(.WORDS(WORDS)) u_beat_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (r_state == ST_IDLE),
    .i_en    (w_beat),
    .o_count (w_count),
    .o_last  (w_last)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Capture the miss context when a refill is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tag   <= '0;
      r_vtag  <= '0;
      r_index <= '0;
      r_way   <= 1'b0;
    end else if (w_accept) begin
      r_tag   <= miss_addr[TAG_LSB +: TAG_W];
      r_index <= miss_addr[IDX_LSB +: INDEX_W];
      r_way   <= victim_way;
      r_vtag  <= victim_tag;
    end
  end

  // Next-state: write-back only for a valid dirty victim; each phase ends on its last beat.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (miss_req) w_next = (victim_valid && victim_dirty) ? ST_WB : ST_FILL;
      ST_WB:     if (w_beat && w_last) w_next = ST_FILL;
      ST_FILL:   if (w_beat && w_last) w_next = ST_COMMIT;
      ST_COMMIT: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Output decode; array address always reflects the registered line and beat counter.
  always_comb begin
    arr_way       = r_way;
    arr_index     = r_index;
    arr_word      = w_count;
    arr_we        = 1'b0;
    arr_wdata     = '0;
    tag_we        = 1'b0;
    tag_wdata     = '0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    busy          = (r_state != ST_IDLE);
    done          = 1'b0;
    policy_update = 1'b0;
    unique case (r_state)
      ST_WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {r_vtag, r_index, w_count, {OFFSET_W{1'b0}}};
        mem_wdata = arr_rdata;
      end
      ST_FILL: begin
        mem_req   = 1'b1;
        mem_addr  = {r_tag, r_index, w_count, {OFFSET_W{1'b0}}};
        arr_we    = mem_ack;
        arr_wdata = mem_rdata;
      end
      ST_COMMIT: begin
        tag_we        = 1'b1;
        tag_wdata     = r_tag;
        done          = 1'b1;
        policy_update = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
